// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request opcodes and master FSM states.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LW  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LHU = 3'd2,
    LSU_LB  = 3'd3,
    LSU_LBU = 3'd4,
    LSU_SW  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: extract+extend for loads, merge for sub-word stores.
// Purely combinational; no latency, no flow control.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v      = word[{addr, 3'b000} +: 8];
    half_v      = addr[1] ? word[31:16] : word[15:0];
    load_data   = word;
    merged_word = word;
    case (lsu_op_e'(op))
      LSU_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      LSU_LBU: load_data = {24'h0, byte_v};
      LSU_LH:  load_data = {{16{half_v[15]}}, half_v};
      LSU_LHU: load_data = {16'h0, half_v};
      LSU_SB:  merged_word[{addr, 3'b000} +: 8] = wdata[7:0];
      LSU_SH:  merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between MEM stage and word-wide data memory; latency 2 (load/SW), 3 (SH/SB), 1 (error).
// One request in flight; req_ready only in IDLE, response held until rsp_ready.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_HI     = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [31:0]         req_pc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic [ADDR_HI-2:0]  mem_addr,
  output logic                mem_we,
  output logic [31:0]         mem_wd,
  output logic [31:0]         mem_pc,
  input  logic [31:0]         mem_rd
);

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q;
  logic [ADDR_HI:0]  addr_q;
  logic [31:0]       wdata_q, pc_q, word_q, rsp_data_q;
  logic              rsp_err_q;
  logic              accept, req_err, op_is_load;
  logic [31:0]       lane_word, load_data, merged_word;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    case (lsu_op_e'(req_op))
      LSU_LW, LSU_SW:          req_err = (req_addr[1:0] != 2'b00);
      LSU_LH, LSU_LHU, LSU_SH: req_err = req_addr[0];
      LSU_LB, LSU_LBU, LSU_SB: req_err = 1'b0;
      default:                 req_err = 1'b1;
    endcase
    if (req_addr[31:ADDR_HI+1] != '0) req_err = 1'b1;
    if (32'(req_addr[ADDR_HI:2]) >= 32'(DEPTH_WORDS)) req_err = 1'b1;
  end

  always_comb begin
    op_is_load = 1'b0;
    case (op_q)
      LSU_LW, LSU_LH, LSU_LHU, LSU_LB, LSU_LBU: op_is_load = 1'b1;
      default:                                  op_is_load = 1'b0;
    endcase
  end

  // The merge pass reuses the lane unit on the word captured during ACCESS.
  assign lane_word = (state_q == WRITE) ? word_q : mem_rd;

  lsu_lane u_lane (
    .op          (op_q),
    .addr        (addr_q[1:0]),
    .word        (lane_word),
    .wdata       (wdata_q[15:0]),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= LSU_LW;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      word_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= lsu_op_e'(req_op);
        addr_q     <= req_addr[ADDR_HI:0];
        wdata_q    <= req_wdata;
        pc_q       <= req_pc;
        rsp_data_q <= '0;
        rsp_err_q  <= req_err;
      end
      if (state_q == ACCESS) begin
        word_q <= mem_rd;
        if (op_is_load) rsp_data_q <= load_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_wd    = '0;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    case (state_q)
      IDLE: begin
        if (accept) state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (op_q == LSU_SW) begin
          mem_we  = 1'b1;
          mem_wd  = wdata_q;
          state_d = RESP;
        end else if (op_q == LSU_SH || op_q == LSU_SB) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        mem_wd  = merged_word;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = addr_q[ADDR_HI:2];
  assign mem_pc   = pc_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, hand-written stall/reset
// sequences, and randomized traffic against a byte-level reference model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int DEPTH = 3072;

  logic        clk, reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, mem_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc, rsp_data, mem_wd, mem_pc, mem_rd;
  logic [11:0] mem_addr;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  logic [31:0] last_wd, last_pc;
  logic [11:0] last_wa;

  lsu_mem_master #(.DEPTH_WORDS(DEPTH), .ADDR_HI(13)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: combinational read, write on the clock edge.
  assign mem_rd = (int'(mem_addr) < DEPTH) ? mem[mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (int'(mem_addr) < DEPTH) mem[mem_addr] <= mem_wd;
      wr_count <= wr_count + 1;
      last_wd  <= mem_wd;
      last_wa  <= mem_addr;
      last_pc  <= mem_pc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed view of memory with plain arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] d, output logic e, output int lat,
                       output int nw, output logic [31:0] ewd);
    int          size, sh;
    int unsigned idx;
    logic        is_st, sgn;
    logic [63:0] mask, v;
    case (op)
      3'd0, 3'd5:       size = 4;
      3'd1, 3'd2, 3'd6: size = 2;
      default:          size = 1;
    endcase
    is_st = (op >= 3'd5);
    sgn   = (op == 3'd1) || (op == 3'd3);
    sh    = int'(addr % 4) * 8;
    e     = ((addr % size) != 0) || (addr >= DEPTH * 4);
    d = 32'h0; lat = 1; nw = 0; ewd = 32'h0;
    if (!e) begin
      idx  = addr / 4;
      mask = ((64'd1 << (8 * size)) - 64'd1) << sh;
      if (is_st) begin
        v = ({32'h0, ref_mem[idx]} & ~mask) | (({32'h0, wd} << sh) & mask);
        ref_mem[idx] = v[31:0];
        nw  = 1;
        ewd = v[31:0];
        lat = (size == 4) ? 2 : 3;
      end else begin
        v = ({32'h0, ref_mem[idx]} & mask) >> sh;
        if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        d   = v[31:0];
        lat = 2;
      end
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] pc, input int hold,
                        output logic [31:0] d, output logic e, output int lat, output int nw);
    int w0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc;
    w0 = wr_count;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rsp_data;
    e = rsp_err;
    repeat (hold) begin @(posedge clk); #1; end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    nw = wr_count - w0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr, wdata, data;
    logic        err;
    int          lat, nw;
    logic [31:0] wd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] data, input logic err, input int lat, input int nw,
                     input logic [31:0] wd);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.data = data;
    v.err = err; v.lat = lat; v.nw = nw; v.wd = wd;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] d, md, mwd, pc;
    logic        e, me;
    int          lat, mlat, nw, mnw, w0, n, r;
    logic [31:0] idx, addr;
    logic [2:0]  op;

    for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;

    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data,       32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wd",    mem_wd,         32'h0);
    chk("rst_mem_pc",    mem_pc,         32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    add(LSU_SW,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF);
    add(LSU_LW,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
    add(LSU_LB,  32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 32'h0);
    add(LSU_LBU, 32'h13,   32'h0,        32'h000000DE, 1'b0, 2, 0, 32'h0);
    add(LSU_LH,  32'h12,   32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 32'h0);
    add(LSU_LHU, 32'h10,   32'h0,        32'h0000BEEF, 1'b0, 2, 0, 32'h0);
    add(LSU_SB,  32'h11,   32'h12345677, 32'h0,        1'b0, 3, 1, 32'hDEAD77EF);
    add(LSU_LW,  32'h10,   32'h0,        32'hDEAD77EF, 1'b0, 2, 0, 32'h0);
    add(LSU_SW,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF);
    add(LSU_SH,  32'h12,   32'hAAAA5555, 32'h0,        1'b0, 3, 1, 32'h5555BEEF);
    add(LSU_LW,  32'h10,   32'h0,        32'h5555BEEF, 1'b0, 2, 0, 32'h0);
    add(LSU_LW,  32'h11,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0);
    add(LSU_SH,  32'h13,   32'h1234,     32'h0,        1'b1, 1, 0, 32'h0);
    add(LSU_SW,  32'h3000, 32'h11111111, 32'h0,        1'b1, 1, 0, 32'h0);
    add(LSU_LH,  32'h11,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0);
    add(LSU_LB,  32'h4000, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0);
    add(LSU_SW,  32'h2FFC, 32'h01234567, 32'h0,        1'b0, 2, 1, 32'h01234567);
    add(LSU_LW,  32'h2FFC, 32'h0,        32'h01234567, 1'b0, 2, 0, 32'h0);

    foreach (vt[i]) begin
      pc = 32'h1000 + 32'(i) * 4;
      model(vt[i].op, vt[i].addr, vt[i].wdata, md, me, mlat, mnw, mwd);
      do_req(vt[i].op, vt[i].addr, vt[i].wdata, pc, i % 3, d, e, lat, nw);
      chk($sformatf("vec%0d_data", i), d, vt[i].data);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_writes", i), 32'(nw), 32'(vt[i].nw));
      if (vt[i].nw == 1) begin
        chk($sformatf("vec%0d_wd", i), last_wd, vt[i].wd);
        chk($sformatf("vec%0d_waddr", i), 32'(last_wa), vt[i].addr >> 2);
        chk($sformatf("vec%0d_wpc", i), last_pc, pc);
      end
    end

    // Backpressure: response held for 5 cycles while a second request is offered.
    @(negedge clk);
    req_valid = 1'b1; req_op = LSU_LW; req_addr = 32'h10; req_pc = 32'h2000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_rsp_lat", 32'(n), 32'd2);
    w0 = wr_count;
    req_valid = 1'b1; req_op = LSU_SW; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data",  rsp_data,       32'h5555BEEF);
      chk("bp_rsp_err",   32'(rsp_err),   32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    chk("bp_no_write", 32'(wr_count - w0), 32'd0);
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("bp_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_rel_req_ready", 32'(req_ready), 32'd1);
    model(LSU_LW, 32'h20, 32'h0, md, me, mlat, mnw, mwd);
    do_req(LSU_LW, 32'h20, 32'h0, 32'h2004, 0, d, e, lat, nw);
    chk("bp_second_not_taken", d, md);

    // Async reset in the middle of an SB read-modify-write.
    model(LSU_SW, 32'h30, 32'hCAFEF00D, md, me, mlat, mnw, mwd);
    do_req(LSU_SW, 32'h30, 32'hCAFEF00D, 32'h3000, 0, d, e, lat, nw);
    @(negedge clk);
    req_valid = 1'b1; req_op = LSU_SB; req_addr = 32'h30; req_wdata = 32'h11; req_pc = 32'h3004;
    w0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_in_write", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_we",    32'(mem_we),    32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_mem_addr",  32'(mem_addr),  32'd0);
    chk("arst_mem_wd",    mem_wd,         32'h0);
    chk("arst_mem_pc",    mem_pc,         32'h0);
    @(posedge clk); #1;
    chk("arst_no_write", 32'(wr_count - w0), 32'd0);
    chk("arst_mem_word", mem[12], 32'hCAFEF00D);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_req_ready", 32'(req_ready), 32'd1);
    chk("arst_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    model(LSU_LW, 32'h30, 32'h0, md, me, mlat, mnw, mwd);
    do_req(LSU_LW, 32'h30, 32'h0, 32'h3008, 0, d, e, lat, nw);
    chk("arst_word_kept", d, md);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 300; t++) begin
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r <= 6)      idx = 32'($urandom_range(0, 15));
      else if (r == 7) idx = 32'($urandom_range(DEPTH - 4, DEPTH + 3));
      else             idx = 32'($urandom_range(0, DEPTH - 1));
      addr = idx * 4 + 32'($urandom_range(0, 3));
      if (r == 8) addr = $urandom;
      req_wdata = $urandom;
      pc = $urandom;
      mwd = req_wdata;
      model(op, addr, mwd, md, me, mlat, mnw, mwd);
      do_req(op, addr, req_wdata, pc, $urandom_range(0, 3), d, e, lat, nw);
      chk($sformatf("rnd%0d_data", t), d, md);
      chk($sformatf("rnd%0d_err", t), 32'(e), 32'(me));
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_writes", t), 32'(nw), 32'(mnw));
      if (mnw == 1 && nw == 1) begin
        chk($sformatf("rnd%0d_wd", t), last_wd, mwd);
        chk($sformatf("rnd%0d_waddr", t), 32'(last_wa), addr >> 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the pipeline MEM stage and the word-wide data memory.
- Accepts one byte/halfword/word request through a valid/ready handshake.
- Drives the memory's word address, write-enable and write-data, and reads its combinational read data.
- Returns sign- or zero-extended load data, or an error for misaligned or out-of-range accesses. Sub-word stores are done as read-modify-write.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in data memory; valid word index range is 0..DEPTH_WORDS-1.
- ADDR_HI, 13, top bit of the memory word address (memory address is [ADDR_HI:2]).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  LSU_LW/LH/LHU/LB/LBU/SW/SH/SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bits are used for SB/SH.
- req_pc  in  32  PC of the issuing instruction.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- mem_addr  out  ADDR_HI-1  word address to memory.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_pc  out  32  PC forwarded to memory for the write log.
- mem_rd  in  32  combinational memory read data at mem_addr.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0.
  - mem_we=0; mem_addr=0; mem_wd=0; mem_pc=0.
  - A reset mid-RMW aborts with no write issued.
- mem_we is asserted only in ACCESS (SW) or WRITE (SH/SB), for exactly one cycle per store. It is never asserted in any other state.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1. A request is accepted when req_valid&req_ready; op, addr, wdata and pc are latched.
  - Error check on the latched values:
    - misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0;
    - out of range: addr[31:ADDR_HI+1]!=0, or word index >= DEPTH_WORDS.
  - Error -> RESP with rsp_err=1, rsp_data=0; memory is not touched. Otherwise -> ACCESS.
- ACCESS (one cycle):
  - mem_addr = latched addr[ADDR_HI:2]; mem_pc = latched pc.
  - Load: capture mem_rd and extract the lane (byte lane = addr[1:0], halfword lane = addr[1]). LB/LH sign-extend; LBU/LHU zero-extend. -> RESP.
  - SW: mem_we=1, mem_wd=wdata -> RESP.
  - SH/SB: capture mem_rd into the merge register -> WRITE.
- WRITE (one cycle):
  - mem_we=1; mem_wd = captured word with the target byte/halfword replaced by wdata[7:0]/[15:0]; all other bytes are unchanged. -> RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready=1, then -> IDLE.
  - req_ready=0 in every state except IDLE, so a new request is accepted no sooner than the cycle after the handshake.
- Latency from accept to rsp_valid:
  - load and SW: 2 cycles;
  - SH/SB: 3 cycles;
  - error: 1 cycle.
- Unknown req_op encodings are treated as error.

Decomposition:
- Shared package lsu_pkg holds:
  - req_op encodings LSU_LW=0, LSU_LH=1, LSU_LHU=2, LSU_LB=3, LSU_LBU=4, LSU_SW=5, LSU_SH=6, LSU_SB=7;
  - FSM state encodings.
- One combinational sub-module, lsu_lane, handles both directions: lane extract + extend for loads, and lane merge for stores. Inputs: op, addr[1:0], word, wdata. Outputs: load_data, merged_word.

Test Plan:
- Store then load:
  - SW addr=0x10, wdata=0xDEADBEEF -> one mem_we pulse, mem_addr=4, mem_wd=0xDEADBEEF; rsp 2 cycles after accept, rsp_err=0.
  - LW 0x10 -> rsp_data=0xDEADBEEF.
- Extension, with memory word 0x10 = 0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE;
  - LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- RMW stores:
  - SB 0x11 wdata=0x12345677 on 0xDEADBEEF -> exactly one write, mem_wd=0xDEAD77EF, 3-cycle latency.
  - SH 0x12 wdata=0xAAAA5555 -> mem_wd=0x5555BEEF.
- Errors:
  - LW 0x11, SH 0x13, SW 0x00003000 -> rsp_err=1 after 1 cycle, mem_we never asserted.
  - Unknown op: no case is covered, because lsu_pkg defines all eight 3-bit encodings, so none is unknown.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stable; req_ready=0 and a second req_valid is not accepted.
  - rsp_ready=1 -> IDLE next cycle, req_ready=1.
- Async reset:
  - Assert reset=0 during WRITE of an SB -> outputs go to reset values immediately, no mem_we pulse, memory word unchanged.
  - Release -> req_ready=1 on the first clk edge.
